// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: issue request, register-file read/writeback snoop, and operand output.
interface operand_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              req_valid_i, req_ready_o;
  logic [ADDR_W-1:0] req_rn_i, req_rm_i, req_dest_i;
  logic              req_dest_en_i;
  logic [ADDR_W-1:0] rd_addr1_o, rd_addr2_o;
  logic [DATA_W-1:0] rd_data1_i, rd_data2_i;
  logic              wb_en_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic              op_valid_o, op_ready_i;
  logic [DATA_W-1:0] op_a_o, op_b_o;
  logic [ADDR_W-1:0] op_dest_o;
  logic              op_dest_en_o;

  modport slave (
    input  req_valid_i, req_rn_i, req_rm_i, req_dest_i, req_dest_en_i,
    output req_ready_o,
    output rd_addr1_o, rd_addr2_o,
    input  rd_data1_i, rd_data2_i,
    input  wb_en_i, wb_addr_i, wb_data_i,
    output op_valid_o, op_a_o, op_b_o, op_dest_o, op_dest_en_o,
    input  op_ready_i
  );

  modport master (
    output req_valid_i, req_rn_i, req_rm_i, req_dest_i, req_dest_en_i,
    input  req_ready_o,
    input  rd_addr1_o, rd_addr2_o,
    output rd_data1_i, rd_data2_i,
    output wb_en_i, wb_addr_i, wb_data_i,
    input  op_valid_o, op_a_o, op_b_o, op_dest_o, op_dest_en_o,
    output op_ready_i
  );
endinterface

// File: rtl/operand_fetch.sv
// Two-stage operand fetch with busy-bit scoreboard, writeback forwarding and
// in-place operand refresh while the output is stalled.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input logic            clk_i,
  input logic            rst_n_i,
  operand_fetch_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rn;
    logic [ADDR_W-1:0] rm;
    logic [ADDR_W-1:0] dest;
    logic              dest_en;
  } req_t;

  logic [NREG-1:0]   busy_q, busy_d;
  logic              s1_vld_q, op_vld_q;
  req_t              s1_q, op_q, req;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic              wb_en_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  logic              hazard, s1_adv, req_rdy, accept;
  logic [DATA_W-1:0] s1_a, s1_b, ld_a, ld_b, hd_a, hd_b;

  assign req = '{rn: bus.req_rn_i, rm: bus.req_rm_i,
                 dest: bus.req_dest_i, dest_en: bus.req_dest_en_i};

  // A busy source being retired this very cycle is not a hazard.
  assign hazard = (busy_q[req.rn] && !(bus.wb_en_i && bus.wb_addr_i == req.rn)) ||
                  (busy_q[req.rm] && !(bus.wb_en_i && bus.wb_addr_i == req.rm));
  assign s1_adv  = !op_vld_q || bus.op_ready_i;
  assign req_rdy = !hazard && (!s1_vld_q || s1_adv);
  assign accept  = bus.req_valid_i && req_rdy;

  for (genvar i = 0; i < NREG; i++) begin : g_busy
    logic set, clr;
    assign set       = accept && req.dest_en && req.dest == ADDR_W'(i);
    assign clr       = bus.wb_en_i && bus.wb_addr_i == ADDR_W'(i);
    assign busy_d[i] = set || (busy_q[i] && !clr);
  end

  // A write retired on the edge that sampled the read address is not yet in rd_data.
  assign s1_a = (wb_en_q && wb_addr_q == s1_q.rn) ? wb_data_q : bus.rd_data1_i;
  assign s1_b = (wb_en_q && wb_addr_q == s1_q.rm) ? wb_data_q : bus.rd_data2_i;
  assign ld_a = (bus.wb_en_i && bus.wb_addr_i == s1_q.rn) ? bus.wb_data_i : s1_a;
  assign ld_b = (bus.wb_en_i && bus.wb_addr_i == s1_q.rm) ? bus.wb_data_i : s1_b;
  assign hd_a = (bus.wb_en_i && bus.wb_addr_i == op_q.rn) ? bus.wb_data_i : op_a_q;
  assign hd_b = (bus.wb_en_i && bus.wb_addr_i == op_q.rm) ? bus.wb_data_i : op_b_q;

  assign bus.req_ready_o  = req_rdy;
  assign bus.rd_addr1_o   = (s1_vld_q && !s1_adv) ? s1_q.rn : req.rn;
  assign bus.rd_addr2_o   = (s1_vld_q && !s1_adv) ? s1_q.rm : req.rm;
  assign bus.op_valid_o   = op_vld_q;
  assign bus.op_a_o       = op_a_q;
  assign bus.op_b_o       = op_b_q;
  assign bus.op_dest_o    = op_q.dest;
  assign bus.op_dest_en_o = op_q.dest_en;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      op_vld_q  <= 1'b0;
      op_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      busy_q    <= busy_d;
      wb_en_q   <= bus.wb_en_i;
      wb_addr_q <= bus.wb_addr_i;
      wb_data_q <= bus.wb_data_i;
      if (accept) begin
        s1_vld_q <= 1'b1;
        s1_q     <= req;
      end else if (s1_adv) begin
        s1_vld_q <= 1'b0;
      end
      if (s1_adv) begin
        op_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          op_q   <= s1_q;
          op_a_q <= ld_a;
          op_b_q <= ld_b;
        end
      end else begin
        op_a_q <= hd_a;
        op_b_q <= hd_b;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small 2R1W register file model.
module tb_operand_fetch;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  operand_fetch_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  operand_fetch #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Register file: read address sampled at posedge, old data on a same-edge write.
  logic [DW-1:0] rf [16];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'h100 + i;
      rf[1] <= 32'h11;
      rf[2] <= 32'h22;
      bus.rd_data1_i <= '0;
      bus.rd_data2_i <= '0;
    end else begin
      bus.rd_data1_i <= rf[bus.rd_addr1_o];
      bus.rd_data2_i <= rf[bus.rd_addr2_o];
      if (bus.wb_en_i) rf[bus.wb_addr_i] <= bus.wb_data_i;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                     input logic [3:0] dest, input logic den);
    bus.req_valid_i   = v;
    bus.req_rn_i      = rn;
    bus.req_rm_i      = rm;
    bus.req_dest_i    = dest;
    bus.req_dest_en_i = den;
  endtask

  task automatic wb(input logic en, input logic [3:0] a, input logic [31:0] d);
    bus.wb_en_i   = en;
    bus.wb_addr_i = a;
    bus.wb_data_i = d;
  endtask

  initial begin
    req(0, 0, 0, 0, 0);
    wb(0, 0, 0);
    bus.op_ready_i = 1'b1;
    tick(); tick();
    chk("rst_op_valid", 32'(bus.op_valid_o), 0);
    chk("rst_op_a", bus.op_a_o, 0);
    chk("rst_op_b", bus.op_b_o, 0);
    chk("rst_dest", 32'(bus.op_dest_o), 0);
    chk("rst_dest_en", 32'(bus.op_dest_en_o), 0);
    chk("rst_ready", 32'(bus.req_ready_o), 1);
    rst_n = 1'b1;
    tick();

    // basic fetch, latency 2 edges
    req(1, 1, 2, 0, 0); #1;
    chk("b_ready", 32'(bus.req_ready_o), 1);
    tick(); req(0, 0, 0, 0, 0);
    chk("b_lat1_valid", 32'(bus.op_valid_o), 0);
    tick();
    chk("b_valid", 32'(bus.op_valid_o), 1);
    chk("b_a", bus.op_a_o, 32'h11);
    chk("b_b", bus.op_b_o, 32'h22);
    tick();
    chk("b_drop", 32'(bus.op_valid_o), 0);

    // RAW stall on r3, released by same-cycle writeback, wb_q forward
    req(1, 0, 0, 3, 1); #1;
    chk("h_ready0", 32'(bus.req_ready_o), 1);
    tick(); req(1, 3, 0, 0, 0); #1;
    chk("h_stall1", 32'(bus.req_ready_o), 0);
    tick();
    chk("h_dest", 32'(bus.op_dest_o), 3);
    chk("h_dest_en", 32'(bus.op_dest_en_o), 1);
    chk("h_stall2", 32'(bus.req_ready_o), 0);
    tick();
    chk("h_stall3", 32'(bus.req_ready_o), 0);
    wb(1, 3, 32'hABCD); #1;
    chk("h_release", 32'(bus.req_ready_o), 1);
    tick(); wb(0, 0, 0); req(0, 0, 0, 0, 0);
    tick();
    chk("h_valid", 32'(bus.op_valid_o), 1);
    chk("h_a_fwd", bus.op_a_o, 32'hABCD);
    chk("h_b", bus.op_b_o, 32'h100);
    chk("h_dest_en2", 32'(bus.op_dest_en_o), 0);
    tick();

    // output stall with in-place snoop of r5
    bus.op_ready_i = 1'b0;
    req(1, 5, 2, 0, 0);
    tick(); req(1, 1, 1, 0, 0);
    tick(); req(1, 2, 2, 0, 0);
    chk("s_a0", bus.op_a_o, 32'h105);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s_hold_valid", 32'(bus.op_valid_o), 1);
      chk("s_hold_ready", 32'(bus.req_ready_o), 0);
      chk("s_hold_a", bus.op_a_o, 32'h105);
    end
    chk("s_rd_addr1", 32'(bus.rd_addr1_o), 1);
    wb(1, 5, 32'h55);
    tick(); wb(0, 0, 0);
    chk("s_snoop_a", bus.op_a_o, 32'h55);
    chk("s_snoop_b", bus.op_b_o, 32'h22);
    chk("s_ready_full", 32'(bus.req_ready_o), 0);
    bus.op_ready_i = 1'b1; #1;
    chk("s_ready_go", 32'(bus.req_ready_o), 1);
    tick(); req(0, 0, 0, 0, 0);
    chk("s_c_a", bus.op_a_o, 32'h11);
    chk("s_c_b", bus.op_b_o, 32'h11);
    tick();
    chk("s_d_a", bus.op_a_o, 32'h22);
    tick();
    chk("s_drain", 32'(bus.op_valid_o), 0);

    // set and clear of r4 in the same cycle: set wins
    req(1, 0, 0, 4, 1); wb(1, 4, 32'h44);
    tick(); wb(0, 0, 0); req(1, 4, 0, 0, 0); #1;
    chk("sc_stall1", 32'(bus.req_ready_o), 0);
    tick();
    chk("sc_stall2", 32'(bus.req_ready_o), 0);
    wb(1, 4, 32'h444); #1;
    chk("sc_release", 32'(bus.req_ready_o), 1);
    tick(); wb(0, 0, 0); req(0, 0, 0, 0, 0);
    tick();
    chk("sc_a", bus.op_a_o, 32'h444);
    tick();

    // three back-to-back, rn==rm in the middle
    req(1, 1, 2, 0, 0);
    tick(); req(1, 7, 7, 0, 0);
    tick(); req(1, 2, 1, 0, 0);
    chk("bb1_a", bus.op_a_o, 32'h11);
    chk("bb1_b", bus.op_b_o, 32'h22);
    tick(); req(0, 0, 0, 0, 0);
    chk("bb2_valid", 32'(bus.op_valid_o), 1);
    chk("bb2_a", bus.op_a_o, 32'h107);
    chk("bb2_b", bus.op_b_o, 32'h107);
    tick();
    chk("bb3_a", bus.op_a_o, 32'h22);
    chk("bb3_b", bus.op_b_o, 32'h11);
    tick();
    chk("bb_drain", 32'(bus.op_valid_o), 0);

    // reset with S1 and output full and r6 busy
    bus.op_ready_i = 1'b0;
    req(1, 0, 0, 6, 1);
    tick(); req(1, 1, 1, 0, 0);
    tick(); req(0, 0, 0, 0, 0);
    chk("r_pre_valid", 32'(bus.op_valid_o), 1);
    rst_n = 1'b0; #1;
    chk("r_valid", 32'(bus.op_valid_o), 0);
    chk("r_a", bus.op_a_o, 0);
    chk("r_dest_en", 32'(bus.op_dest_en_o), 0);
    tick(); tick();
    rst_n = 1'b1;
    bus.op_ready_i = 1'b1;
    req(1, 6, 0, 0, 0); #1;
    chk("r_no_stall", 32'(bus.req_ready_o), 1);
    tick(); req(0, 0, 0, 0, 0);
    chk("r_s1_discard", 32'(bus.op_valid_o), 0);
    tick();
    chk("r6_valid", 32'(bus.op_valid_o), 1);
    chk("r6_a", bus.op_a_o, 32'h106);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
